// File: rtl/lbm_pkg.sv
// Shared constants and state encoding for the lattice moment storage.
package lbm_pkg;

    localparam int unsigned LBM_NX         = 16;
    localparam int unsigned LBM_NY         = 16;
    localparam int unsigned LBM_DATA_WIDTH = 32;
    localparam int unsigned LBM_NUM_CH     = 3;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        SCAN
    } bank_state_t;

endpackage

// File: rtl/moment_lane_ram.sv
// One moment channel: DEPTH x DATA_WIDTH storage, one write port and one
// registered read port with read-first behaviour on address collision.
module moment_lane_ram #(
    parameter int DEPTH         = 256,
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     we_i,
    input  logic [ADDRESS_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0]    wdata_i,
    input  logic                     re_i,
    input  logic [ADDRESS_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0]    rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Only the output register is reset; the array is zeroed by the owner.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/moment_bank.sv
// Per-cell moment storage (rho, ux, uy) with random read/write access and a
// flow-controlled full-lattice scan through a 2-entry output FIFO.
module moment_bank
    import lbm_pkg::*;
#(
    parameter int NX            = LBM_NX,
    parameter int NY            = LBM_NY,
    parameter int DEPTH         = NX * NY,
    parameter int ADDRESS_WIDTH = $clog2(DEPTH),
    parameter int DATA_WIDTH    = LBM_DATA_WIDTH,
    parameter int NUM_CH        = LBM_NUM_CH
) (
    input  logic                                     Clk,
    input  logic                                     Reset,
    input  logic                                     wr_en,
    input  logic        [ADDRESS_WIDTH-1:0]          wr_addr,
    input  logic        [NUM_CH-1:0]                 wr_mask,
    input  logic signed [NUM_CH-1:0][DATA_WIDTH-1:0] wr_data,
    input  logic                                     rd_en,
    input  logic        [ADDRESS_WIDTH-1:0]          rd_addr,
    output logic signed [NUM_CH-1:0][DATA_WIDTH-1:0] rd_data,
    output logic                                     rd_valid,
    input  logic                                     scan_start,
    output logic                                     scan_valid,
    input  logic                                     scan_ready,
    output logic        [ADDRESS_WIDTH-1:0]          scan_addr,
    output logic signed [NUM_CH-1:0][DATA_WIDTH-1:0] scan_data,
    output logic                                     scan_done,
    output logic                                     busy
);

    typedef logic [NUM_CH-1:0][DATA_WIDTH-1:0] vec_t;
    localparam logic [ADDRESS_WIDTH-1:0] LAST = ADDRESS_WIDTH'(DEPTH - 1);
    localparam logic [ADDRESS_WIDTH-1:0] ONE  = ADDRESS_WIDTH'(1);

    bank_state_t state_q, state_d;
    logic in_clear, in_idle, in_scan;

    logic [ADDRESS_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic [ADDRESS_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
    logic                     fetch_done_q, fetch_done_d;
    logic                     infl_q, infl_d;
    logic [ADDRESS_WIDTH-1:0] infl_addr_q, infl_addr_d;
    logic                     rd_valid_q, rd_valid_d;
    logic                     scan_done_q, scan_done_d;
    logic [1:0]               fifo_cnt_q, fifo_cnt_d;
    vec_t                     fifo_data_q [2];
    vec_t                     fifo_data_d [2];
    logic [ADDRESS_WIDTH-1:0] fifo_addr_q [2];
    logic [ADDRESS_WIDTH-1:0] fifo_addr_d [2];

    logic                     rd_take, fetch, pop, last_pop;
    logic                     ram_re;
    logic [ADDRESS_WIDTH-1:0] ram_raddr, ram_waddr;
    vec_t                     ram_wdata, ram_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CLEAR:   if (clr_cnt_q == LAST) state_d = IDLE;
            IDLE:    if (scan_start) state_d = SCAN;
            SCAN:    if (last_pop) state_d = IDLE;
            default: state_d = CLEAR;
        endcase
    end

    always_comb begin
        in_clear = (state_q == CLEAR);
        in_idle  = (state_q == IDLE);
        in_scan  = (state_q == SCAN);
        busy     = !in_idle;
    end

    // Fetch may only issue if the FIFO has room for it after this cycle's pop.
    always_comb begin
        rd_take  = rd_en & ~in_clear;
        pop      = (fifo_cnt_q != 2'd0) & scan_ready;
        fetch    = in_scan & ~fetch_done_q & ~rd_take &
                   (({1'b0, fifo_cnt_q} + 3'(infl_q)) < (3'd2 + 3'(pop)));
        last_pop = pop & (fifo_addr_q[0] == LAST);

        ram_re    = rd_take | fetch;
        ram_raddr = rd_take ? rd_addr : fetch_addr_q;
        ram_waddr = in_clear ? clr_cnt_q : wr_addr;
        ram_wdata = in_clear ? '0 : vec_t'(wr_data);
    end

    always_comb begin
        clr_cnt_d    = in_clear ? clr_cnt_q + ONE : '0;
        rd_valid_d   = rd_take;
        scan_done_d  = last_pop;
        infl_d       = fetch;
        infl_addr_d  = fetch ? fetch_addr_q : infl_addr_q;
        fetch_addr_d = fetch_addr_q;
        fetch_done_d = fetch_done_q;
        if (in_idle && scan_start) begin
            fetch_addr_d = '0;
            fetch_done_d = 1'b0;
        end else if (fetch) begin
            if (fetch_addr_q == LAST) fetch_done_d = 1'b1;
            else                      fetch_addr_d = fetch_addr_q + ONE;
        end

        fifo_cnt_d  = fifo_cnt_q;
        fifo_data_d = fifo_data_q;
        fifo_addr_d = fifo_addr_q;
        unique case ({infl_q, pop})
            2'b10: begin
                if (fifo_cnt_q == 2'd0) begin
                    fifo_data_d[0] = ram_q;
                    fifo_addr_d[0] = infl_addr_q;
                end else begin
                    fifo_data_d[1] = ram_q;
                    fifo_addr_d[1] = infl_addr_q;
                end
                fifo_cnt_d = fifo_cnt_q + 2'd1;
            end
            2'b01: begin
                fifo_data_d[0] = fifo_data_q[1];
                fifo_addr_d[0] = fifo_addr_q[1];
                fifo_cnt_d     = fifo_cnt_q - 2'd1;
            end
            2'b11: begin
                if (fifo_cnt_q == 2'd1) begin
                    fifo_data_d[0] = ram_q;
                    fifo_addr_d[0] = infl_addr_q;
                end else begin
                    fifo_data_d[0] = fifo_data_q[1];
                    fifo_addr_d[0] = fifo_addr_q[1];
                    fifo_data_d[1] = ram_q;
                    fifo_addr_d[1] = infl_addr_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            clr_cnt_q    <= '0;
            fetch_addr_q <= '0;
            fetch_done_q <= 1'b0;
            infl_q       <= 1'b0;
            infl_addr_q  <= '0;
            rd_valid_q   <= 1'b0;
            scan_done_q  <= 1'b0;
            fifo_cnt_q   <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_addr_q[i] <= '0;
            end
        end else begin
            clr_cnt_q    <= clr_cnt_d;
            fetch_addr_q <= fetch_addr_d;
            fetch_done_q <= fetch_done_d;
            infl_q       <= infl_d;
            infl_addr_q  <= infl_addr_d;
            rd_valid_q   <= rd_valid_d;
            scan_done_q  <= scan_done_d;
            fifo_cnt_q   <= fifo_cnt_d;
            fifo_data_q  <= fifo_data_d;
            fifo_addr_q  <= fifo_addr_d;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        moment_lane_ram #(
            .DEPTH        (DEPTH),
            .ADDRESS_WIDTH(ADDRESS_WIDTH),
            .DATA_WIDTH   (DATA_WIDTH)
        ) u_lane (
            .clk_i  (Clk),
            .rst_i  (Reset),
            .we_i   (in_clear | (wr_en & wr_mask[c])),
            .waddr_i(ram_waddr),
            .wdata_i(ram_wdata[c]),
            .re_i   (ram_re),
            .raddr_i(ram_raddr),
            .rdata_o(ram_q[c])
        );
    end

    assign rd_data    = ram_q;
    assign rd_valid   = rd_valid_q;
    assign scan_valid = (fifo_cnt_q != 2'd0);
    assign scan_addr  = fifo_addr_q[0];
    assign scan_data  = fifo_data_q[0];
    assign scan_done  = scan_done_q;

endmodule

// File: tb/tb_moment_bank.sv
// Directed bench for moment_bank on a 4x4 lattice with three 16-bit channels.
module tb_moment_bank;

    localparam int NX  = 4;
    localparam int NY  = 4;
    localparam int AW  = 4;
    localparam int DW  = 16;
    localparam int NCH = 3;

    typedef logic [NCH-1:0][DW-1:0] vec_t;

    logic           Clk = 1'b0;
    logic           Reset = 1'b1;
    logic           wr_en = 1'b0;
    logic [AW-1:0]  wr_addr = '0;
    logic [NCH-1:0] wr_mask = '0;
    vec_t           wr_data = '0;
    logic           rd_en = 1'b0;
    logic [AW-1:0]  rd_addr = '0;
    vec_t           rd_data;
    logic           rd_valid;
    logic           scan_start = 1'b0;
    logic           scan_valid;
    logic           scan_ready = 1'b0;
    logic [AW-1:0]  scan_addr;
    vec_t           scan_data;
    logic           scan_done;
    logic           busy;

    int checks   = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    moment_bank #(
        .NX        (NX),
        .NY        (NY),
        .DATA_WIDTH(DW),
        .NUM_CH    (NCH)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_mask   (wr_mask),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .scan_start(scan_start),
        .scan_valid(scan_valid),
        .scan_ready(scan_ready),
        .scan_addr (scan_addr),
        .scan_data (scan_data),
        .scan_done (scan_done),
        .busy      (busy)
    );

    function automatic vec_t mk(input int a, input int b, input int c);
        vec_t v;
        v[0] = DW'(a);
        v[1] = DW'(b);
        v[2] = DW'(c);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic write(input int a, input vec_t v, input logic [NCH-1:0] m);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = v;
        wr_mask = m;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic read_chk(input string tag, input int a, input vec_t exp);
        rd_en   = 1'b1;
        rd_addr = AW'(a);
        tick();
        rd_en   = 1'b0;
        chk({tag, "_valid"}, rd_valid, 1);
        chk(tag, rd_data, exp);
    endtask

    task automatic clear_watch(input string tag);
        int n = 0;
        bit bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            n++;
            if (rd_valid || scan_valid || scan_done) bad = 1'b1;
            tick();
        end
        chk({tag, "_busy_cycles"}, n, 16);
        chk({tag, "_quiet"}, bad, 0);
    endtask

    task automatic run_scan(input string tag, input bit toggle);
        int exp_a = 0;
        int first = -1;
        int last = -1;
        int dones = 0;
        bit stall = 1'b0;
        bit rdp = 1'b0;
        int rda = 0;
        logic [AW-1:0] paddr = '0;
        vec_t pdata = '0;
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (rdp) begin
                chk({tag, "_rd_valid"}, rd_valid, 1);
                chk({tag, "_rd_data"}, rd_data, mk(rda, rda, rda));
                rdp = 1'b0;
            end
            if (scan_done) dones++;
            if (stall) begin
                chk({tag, "_stall_valid"}, scan_valid, 1);
                chk({tag, "_stall_addr"}, scan_addr, paddr);
                chk({tag, "_stall_data"}, scan_data, pdata);
            end
            if (dones > 0 && last >= 0 && c >= last + 4) break;
            scan_ready = toggle ? (c % 2 == 0) : 1'b1;
            rd_en      = toggle && (c == 3 || c == 4);
            scan_start = toggle && (c == 6);
            if (rd_en) begin
                rda     = (c == 3) ? 9 : 12;
                rd_addr = AW'(rda);
                rdp     = 1'b1;
            end
            if (scan_valid && scan_ready) begin
                chk($sformatf("%s_elem%0d_addr", tag, exp_a), scan_addr, exp_a);
                chk($sformatf("%s_elem%0d_data", tag, exp_a), scan_data, mk(exp_a, exp_a, exp_a));
                if (first < 0) first = c;
                last = c;
                exp_a++;
            end
            stall = scan_valid && !scan_ready;
            paddr = scan_addr;
            pdata = scan_data;
            tick();
        end
        rd_en      = 1'b0;
        scan_start = 1'b0;
        chk({tag, "_elements"}, exp_a, 16);
        chk({tag, "_done_pulses"}, dones, 1);
        chk({tag, "_idle_after"}, busy, 0);
        if (!toggle) chk({tag, "_back_to_back"}, last - first, 15);
    endtask

    initial begin
        bit found;

        // Reset values and clear sweep, with requests that must be ignored.
        Reset = 1'b1;
        tick();
        tick();
        chk("rst_busy", busy, 1);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_scan_valid", scan_valid, 0);
        chk("rst_scan_done", scan_done, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_scan_data", scan_data, 0);
        chk("rst_scan_addr", scan_addr, 0);
        Reset      = 1'b0;
        wr_en      = 1'b1;
        wr_addr    = AW'(3);
        wr_data    = mk(7, 7, 7);
        wr_mask    = 3'b111;
        rd_en      = 1'b1;
        rd_addr    = AW'(3);
        scan_start = 1'b1;
        clear_watch("clear");
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        scan_start = 1'b0;
        read_chk("clr_rd0", 0, mk(0, 0, 0));
        read_chk("clr_rd3", 3, mk(0, 0, 0));
        read_chk("clr_rd15", 15, mk(0, 0, 0));
        chk("clr_no_scan", busy, 0);

        // Masked writes.
        write(5, mk(100, -7, 3), 3'b111);
        write(5, mk(1, 1, 1), 3'b010);
        read_chk("mask_rd5", 5, mk(100, 1, 3));
        tick();
        chk("rd_valid_drop", rd_valid, 0);

        // Read-first collision.
        write(2, mk(4, 4, 4), 3'b111);
        wr_en   = 1'b1;
        wr_addr = AW'(2);
        wr_data = mk(9, 9, 9);
        wr_mask = 3'b111;
        read_chk("rf_old", 2, mk(4, 4, 4));
        read_chk("rf_new", 2, mk(9, 9, 9));

        // Scans over address-valued memory.
        for (int i = 0; i < 16; i++) write(i, mk(i, i, i), 3'b111);
        run_scan("scan_full", 1'b0);
        run_scan("scan_stall", 1'b1);

        // Reset in the middle of a scan.
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        scan_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (scan_valid && scan_addr == AW'(7)) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("midrst_reached7", found, 1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("midrst_scan_valid", scan_valid, 0);
        chk("midrst_scan_done", scan_done, 0);
        chk("midrst_busy", busy, 1);
        clear_watch("midrst_clear");
        read_chk("midrst_rd7", 7, mk(0, 0, 0));
        read_chk("midrst_rd15", 15, mk(0, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
